rf_writeback_unit: RTL



---
 rtl/gpu_rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 58 +++++
 rtl/rf_writeback_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/gpu_rf_pkg.sv
// Shared constants and source identifiers for the GPU register-file write side.
package gpu_rf_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue and
// cleared by the committing writeback, plus hazard lookup and a sticky error.
module rf_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_iss_valid,
    input  logic [ADDR_W-1:0]   i_iss_waddr,
    input  logic                i_rf_we,
    input  logic [ADDR_W-1:0]   i_rf_w_addr,
    input  logic [ADDR_W-1:0]   i_chk_addr_a,
    input  logic [ADDR_W-1:0]   i_chk_addr_b,
    input  logic [ADDR_W-1:0]   i_chk_addr_c,
    output logic                o_hazard,
    output logic [NUM_REGS-1:0] o_busy_vec,
    output logic                o_wb_err
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic                r_err;
    logic                w_err_hit;

    // r0 has no mask bits, so its busy bit never leaves its reset value of 0.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_mask
            if (gi == 0) begin : g_zero
                assign w_set_mask[gi] = 1'b0;
                assign w_clr_mask[gi] = 1'b0;
            end else begin : g_reg
                assign w_set_mask[gi] = i_iss_valid && (i_iss_waddr == ADDR_W'(gi));
                assign w_clr_mask[gi] = i_rf_we && (i_rf_w_addr == ADDR_W'(gi));
            end
        end
    endgenerate

    // A commit to an idle register is an error unless issue re-arms it at the same edge.
    assign w_err_hit = i_rf_we && !r_busy[i_rf_w_addr]
                       && !(i_iss_valid && (i_iss_waddr == i_rf_w_addr));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            if (w_err_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_hazard   = r_busy[i_chk_addr_a] | r_busy[i_chk_addr_b] | r_busy[i_chk_addr_c];
    assign o_busy_vec = r_busy;
    assign o_wb_err   = r_err;
endmodule

// File: rtl/rf_writeback_unit.sv
// Write-side master of the register file: round-robin ALU/load arbitration
// into a one-cycle output register, with a pending-write scoreboard alongside.
module rf_writeback_unit
    import gpu_rf_pkg::src_t, gpu_rf_pkg::SRC_ALU, gpu_rf_pkg::SRC_LD;
#(
    parameter int DATA_W   = gpu_rf_pkg::DATA_W,
    parameter int ADDR_W   = gpu_rf_pkg::ADDR_W,
    parameter int NUM_REGS = gpu_rf_pkg::NUM_REGS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_waddr,
    input  logic [DATA_W-1:0]   alu_wdata,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_waddr,
    input  logic [DATA_W-1:0]   ld_wdata,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_waddr,
    input  logic [ADDR_W-1:0]   chk_addr_a,
    input  logic [ADDR_W-1:0]   chk_addr_b,
    input  logic [ADDR_W-1:0]   chk_addr_c,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_w_addr,
    output logic [DATA_W-1:0]   rf_w_data,
    output logic                wb_err
);
    src_t              r_rr_ptr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              w_contested;
    logic              w_grant_ld;
    logic              w_grant_alu;
    logic              w_commit;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    always_comb begin
        w_contested = alu_valid & ld_valid;
        w_grant_ld  = ld_valid & (~alu_valid | (r_rr_ptr == SRC_LD));
        w_grant_alu = alu_valid & ~w_grant_ld;
        w_sel_addr  = w_grant_ld ? ld_waddr : alu_waddr;
        w_sel_data  = w_grant_ld ? ld_wdata : alu_wdata;
        // r0 writes still complete the handshake but never reach the file.
        w_commit    = (w_grant_ld | w_grant_alu) && (w_sel_addr != '0);
    end

    assign alu_ready = w_grant_alu;
    assign ld_ready  = w_grant_ld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= SRC_LD;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            if (w_contested) begin
                r_rr_ptr <= (r_rr_ptr == SRC_LD) ? SRC_ALU : SRC_LD;
            end
            r_we <= w_commit;
            if (w_commit) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    assign rf_we     = r_we;
    assign rf_w_addr = r_addr;
    assign rf_w_data = r_data;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_iss_valid  (iss_valid),
        .i_iss_waddr  (iss_waddr),
        .i_rf_we      (r_we),
        .i_rf_w_addr  (r_addr),
        .i_chk_addr_a (chk_addr_a),
        .i_chk_addr_b (chk_addr_b),
        .i_chk_addr_c (chk_addr_c),
        .o_hazard     (hazard),
        .o_busy_vec   (busy_vec),
        .o_wb_err     (wb_err)
    );
endmodule
